// File: rtl/mem_arbiter_if.sv
// Bus bundle between the mem_arbiter and its surroundings: the instruction
// fetch port, the load/store port and the request port of the byte-serial
// memory access unit. The arbiter connects through the slave modport; the
// environment (requesters plus access unit) uses the master modport.
interface mem_arbiter_if #(
   parameter int ADDR_W = 32
);
   // Instruction fetch port
   logic              if_valid;
   logic [ADDR_W-1:0] if_addr;
   logic              if_ready;
   logic [31:0]       if_data;

   // Load/store port
   logic              ls_valid;
   logic              ls_wr;
   logic [ADDR_W-1:0] ls_addr;
   logic [2:0]        ls_len;
   logic [31:0]       ls_data;
   logic              ls_ready;
   logic [31:0]       ls_data_out;

   // Access unit port
   logic              mu_valid;
   logic              mu_wr;
   logic [ADDR_W-1:0] mu_addr;
   logic [2:0]        mu_len;
   logic [31:0]       mu_data;
   logic              mu_ready;
   logic [31:0]       mu_data_out;

   modport slave (
      input  if_valid, if_addr,
      output if_ready, if_data,
      input  ls_valid, ls_wr, ls_addr, ls_len, ls_data,
      output ls_ready, ls_data_out,
      output mu_valid, mu_wr, mu_addr, mu_len, mu_data,
      input  mu_ready, mu_data_out
   );

   modport master (
      output if_valid, if_addr,
      input  if_ready, if_data,
      output ls_valid, ls_wr, ls_addr, ls_len, ls_data,
      input  ls_ready, ls_data_out,
      input  mu_valid, mu_wr, mu_addr, mu_len, mu_data,
      output mu_ready, mu_data_out
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants the instruction fetch port or the load/store port to the
// byte-serial memory access unit, one transaction at a time. The granted
// request is latched and held on the mu_* fields until the next grant; the
// access unit's completion pulse and read data are routed back to the owner.
// A ROB flush aborts the transaction in flight without a completion pulse.
//
// Optional feature: define MEM_ARB_IO_STALL_EN to hold back stores to the
// UART window (ls_addr[17:16] == 2'b11) while io_buffer_full is high.
module mem_arbiter #(
   parameter int ADDR_W = 32
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        rdy_in,
   input  logic        rob_clear,
   input  logic        io_buffer_full,
   mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_LS = 2'd2
   } state_t;

   state_t            state_q;
   logic              lastOwner_q;
   logic              muWr_q;
   logic [ADDR_W-1:0] muAddr_q;
   logic [2:0]        muLen_q;
   logic [31:0]       muData_q;

   logic              lsStall;
   logic              ifEligible;
   logic              lsEligible;
   logic              grantIf;
   logic              grantLs;
   logic              completeOk;

`ifdef MEM_ARB_IO_STALL_EN
   assign lsStall = bus.ls_wr & io_buffer_full & (bus.ls_addr[17:16] == 2'b11);
`else
   logic unusedIoFull;
   assign unusedIoFull = io_buffer_full;
   assign lsStall      = 1'b0;
`endif

   assign ifEligible = bus.if_valid;
   assign lsEligible = bus.ls_valid & ~lsStall;

   // Arbitration: a lone eligible port wins; on a conflict the port that did
   // not own the previous grant wins (last owner 0 = IF, so LS goes first).
   always_comb begin
      grantLs = 1'b0;
      grantIf = 1'b0;
      if (lsEligible && (!ifEligible || !lastOwner_q)) begin
         grantLs = 1'b1;
      end else if (ifEligible) begin
         grantIf = 1'b1;
      end
   end

   // Arbiter FSM: grants in IDLE, latches the request fields, waits for the
   // access unit to complete, and drops back to IDLE on completion or flush.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q     <= IDLE;
         lastOwner_q <= 1'b0;
         muWr_q      <= 1'b0;
         muAddr_q    <= '0;
         muLen_q     <= 3'b000;
         muData_q    <= 32'h0;
      end else if (rdy_in) begin
         if (rob_clear) begin
            state_q <= IDLE;
         end else begin
            case (state_q)
               IDLE: begin
                  if (grantLs) begin
                     state_q     <= BUSY_LS;
                     lastOwner_q <= 1'b1;
                     muWr_q      <= bus.ls_wr;
                     muAddr_q    <= bus.ls_addr;
                     muLen_q     <= bus.ls_len;
                     muData_q    <= bus.ls_data;
                  end else if (grantIf) begin
                     state_q     <= BUSY_IF;
                     lastOwner_q <= 1'b0;
                     muWr_q      <= 1'b0;
                     muAddr_q    <= bus.if_addr;
                     muLen_q     <= 3'b010;
                     muData_q    <= 32'h0;
                  end
               end
               BUSY_IF, BUSY_LS: begin
                  if (bus.mu_ready) begin
                     state_q <= IDLE;
                  end
               end
               default: begin
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

   // A completion only counts when the arbiter is enabled and no flush is
   // discarding it in the same cycle; otherwise the owner sees no pulse.
   assign completeOk = rdy_in & ~rob_clear & bus.mu_ready;

   // Dropping mu_valid in the completion cycle keeps the access unit from
   // restarting on the stale request before the FSM reaches IDLE.
   assign bus.mu_valid    = (state_q != IDLE) & ~bus.mu_ready;
   assign bus.mu_wr       = muWr_q;
   assign bus.mu_addr     = muAddr_q;
   assign bus.mu_len      = muLen_q;
   assign bus.mu_data     = muData_q;

   assign bus.if_ready    = completeOk & (state_q == BUSY_IF);
   assign bus.if_data     = bus.if_ready ? bus.mu_data_out : 32'h0;
   assign bus.ls_ready    = completeOk & (state_q == BUSY_LS);
   assign bus.ls_data_out = bus.ls_ready ? bus.mu_data_out : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter. A small access-unit model answers each
// request N cycles after mu_valid rises (N = 1/2/4 bytes) and freezes with
// rdy_in. Inputs change 1 ns after the rising edge; outputs are probed on the
// falling edge.
module tb_mem_arbiter;

   localparam int ADDR_W = 32;

   logic clk_in = 1'b0;
   logic rst_n_in;
   logic rdy_in;
   logic rob_clear;
   logic io_buffer_full;

   int checkCount;
   int errorCount;

   logic [31:0] readData;
   int unsigned muCnt;

   mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

   mem_arbiter #(.ADDR_W(ADDR_W)) dut (
      .clk_in         (clk_in),
      .rst_n_in       (rst_n_in),
      .rdy_in         (rdy_in),
      .rob_clear      (rob_clear),
      .io_buffer_full (io_buffer_full),
      .bus            (bus)
   );

   // Free-running 10 ns clock
   always #5 clk_in = ~clk_in;

   function automatic int unsigned lenBytes(input logic [2:0] len);
      case (len[1:0])
         2'b00:   return 1;
         2'b01:   return 2;
         default: return 4;
      endcase
   endfunction

   // Access-unit model: counts cycles of mu_valid, restarts on completion or flush
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         muCnt <= 0;
      end else if (rdy_in) begin
         if (bus.mu_ready || rob_clear) begin
            muCnt <= 0;
         end else if (bus.mu_valid) begin
            muCnt <= muCnt + 1;
         end
      end
   end

   assign bus.mu_ready    = (muCnt != 0) && (muCnt == lenBytes(bus.mu_len));
   assign bus.mu_data_out = bus.mu_ready ? readData : 32'h0;

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic ifv, input logic [31:0] ifa,
                                input logic lsv, input logic lswr,
                                input logic [31:0] lsa, input logic [2:0] lslen,
                                input logic [31:0] lsd);
      bus.if_valid = ifv;
      bus.if_addr  = ifa;
      bus.ls_valid = lsv;
      bus.ls_wr    = lswr;
      bus.ls_addr  = lsa;
      bus.ls_len   = lslen;
      bus.ls_data  = lsd;
   endtask

   task automatic toCycle();
      @(posedge clk_in);
      #1;
   endtask

   task automatic probe();
      @(negedge clk_in);
   endtask

   task automatic doReset();
      rst_n_in       = 1'b0;
      rdy_in         = 1'b1;
      rob_clear      = 1'b0;
      io_buffer_full = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
      repeat (2) @(posedge clk_in);
      #1;
      rst_n_in = 1'b1;
   endtask

   initial begin
      checkCount = 0;
      errorCount = 0;
      readData   = 32'h0;

      // Reset values
      doReset();
      probe();
      checkOutput("rst mu_valid", 32'(bus.mu_valid), 32'h0);
      checkOutput("rst mu_wr", 32'(bus.mu_wr), 32'h0);
      checkOutput("rst mu_addr", bus.mu_addr, 32'h0);
      checkOutput("rst mu_len", 32'(bus.mu_len), 32'h0);
      checkOutput("rst mu_data", bus.mu_data, 32'h0);
      checkOutput("rst if_ready", 32'(bus.if_ready), 32'h0);
      checkOutput("rst ls_ready", 32'(bus.ls_ready), 32'h0);
      checkOutput("rst if_data", bus.if_data, 32'h0);
      checkOutput("rst ls_data_out", bus.ls_data_out, 32'h0);

      // Lone fetch: mu_valid cycles 1-4, if_ready at cycle 5
      toCycle();
      readData = 32'hDEADBEEF;
      applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
      probe();
      checkOutput("fetch c0 mu_valid", 32'(bus.mu_valid), 32'h0);
      for (int c = 1; c <= 4; c++) begin
         toCycle();
         probe();
         checkOutput("fetch mu_valid", 32'(bus.mu_valid), 32'h1);
         checkOutput("fetch mu_len", 32'(bus.mu_len), 32'h2);
         checkOutput("fetch mu_wr", 32'(bus.mu_wr), 32'h0);
         checkOutput("fetch mu_addr", bus.mu_addr, 32'h100);
         checkOutput("fetch early if_ready", 32'(bus.if_ready), 32'h0);
         checkOutput("fetch early if_data", bus.if_data, 32'h0);
      end
      toCycle();
      probe();
      checkOutput("fetch c5 if_ready", 32'(bus.if_ready), 32'h1);
      checkOutput("fetch c5 if_data", bus.if_data, 32'hDEADBEEF);
      checkOutput("fetch c5 mu_valid", 32'(bus.mu_valid), 32'h0);
      checkOutput("fetch c5 ls_ready", 32'(bus.ls_ready), 32'h0);
      toCycle();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
      probe();
      checkOutput("fetch c6 mu_valid", 32'(bus.mu_valid), 32'h0);
      checkOutput("fetch c6 if_ready", 32'(bus.if_ready), 32'h0);

      // Conflict after reset: LS first, then IF, then LS again
      doReset();
      toCycle();
      readData = 32'h11112222;
      applyStimulus(1'b1, 32'h104, 1'b1, 1'b0, 32'h200, 3'b010, 32'h0);
      toCycle();
      probe();
      checkOutput("conflict1 mu_addr", bus.mu_addr, 32'h200);
      checkOutput("conflict1 mu_valid", 32'(bus.mu_valid), 32'h1);
      repeat (4) toCycle();
      probe();
      checkOutput("conflict1 ls_ready", 32'(bus.ls_ready), 32'h1);
      checkOutput("conflict1 ls_data_out", bus.ls_data_out, 32'h11112222);
      checkOutput("conflict1 if_ready", 32'(bus.if_ready), 32'h0);
      toCycle();
      readData = 32'h33334444;
      applyStimulus(1'b1, 32'h104, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
      probe();
      checkOutput("conflict idle gap mu_valid", 32'(bus.mu_valid), 32'h0);
      toCycle();
      probe();
      checkOutput("conflict2 mu_valid", 32'(bus.mu_valid), 32'h1);
      checkOutput("conflict2 mu_addr", bus.mu_addr, 32'h104);
      repeat (4) toCycle();
      probe();
      checkOutput("conflict2 if_ready", 32'(bus.if_ready), 32'h1);
      checkOutput("conflict2 if_data", bus.if_data, 32'h33334444);
      toCycle();
      readData = 32'h55556666;
      applyStimulus(1'b1, 32'h108, 1'b1, 1'b0, 32'h204, 3'b010, 32'h0);
      toCycle();
      probe();
      checkOutput("conflict3 mu_addr", bus.mu_addr, 32'h204);
      repeat (4) toCycle();
      probe();
      checkOutput("conflict3 ls_ready", 32'(bus.ls_ready), 32'h1);
      checkOutput("conflict3 ls_data_out", bus.ls_data_out, 32'h55556666);
      toCycle();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0);

      // Byte store: one cycle of mu_valid, ls_ready at cycle 2
      toCycle();
      readData = 32'h0;
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h30000, 3'b000, 32'h41);
      toCycle();
      probe();
      checkOutput("sb mu_valid", 32'(bus.mu_valid), 32'h1);
      checkOutput("sb mu_data", bus.mu_data, 32'h41);
      checkOutput("sb mu_wr", 32'(bus.mu_wr), 32'h1);
      checkOutput("sb mu_len", 32'(bus.mu_len), 32'h0);
      checkOutput("sb early ls_ready", 32'(bus.ls_ready), 32'h0);
      toCycle();
      probe();
      checkOutput("sb ls_ready", 32'(bus.ls_ready), 32'h1);
      checkOutput("sb c2 mu_valid", 32'(bus.mu_valid), 32'h0);
      toCycle();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
      probe();
      checkOutput("sb idle mu_valid", 32'(bus.mu_valid), 32'h0);
      checkOutput("sb held mu_data", bus.mu_data, 32'h41);

      // Flush two cycles into a word load, pending fetch then granted
      toCycle();
      readData = 32'hAAAA0000;
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 3'b010, 32'h0);
      toCycle();
      probe();
      checkOutput("flush c1 mu_valid", 32'(bus.mu_valid), 32'h1);
      toCycle();
      rob_clear = 1'b1;
      applyStimulus(1'b1, 32'h400, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
      probe();
      checkOutput("flush c2 ls_ready", 32'(bus.ls_ready), 32'h0);
      toCycle();
      rob_clear = 1'b0;
      readData  = 32'hBBBB0000;
      probe();
      checkOutput("flush c3 mu_valid", 32'(bus.mu_valid), 32'h0);
      checkOutput("flush c3 ls_ready", 32'(bus.ls_ready), 32'h0);
      toCycle();
      probe();
      checkOutput("flush c4 mu_valid", 32'(bus.mu_valid), 32'h1);
      checkOutput("flush c4 mu_addr", bus.mu_addr, 32'h400);
      repeat (4) toCycle();
      probe();
      checkOutput("flush if_ready", 32'(bus.if_ready), 32'h1);
      checkOutput("flush if_data", bus.if_data, 32'hBBBB0000);
      checkOutput("flush no ls_ready", 32'(bus.ls_ready), 32'h0);
      toCycle();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0);

      // rdy_in low for 3 cycles during a halfword load
      toCycle();
      readData = 32'hFFFF8001;
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h500, 3'b001, 32'h0);
      toCycle();
      probe();
      checkOutput("freeze c1 mu_valid", 32'(bus.mu_valid), 32'h1);
      toCycle();
      rdy_in = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h999, 3'b001, 32'h0);
      toCycle();
      probe();
      checkOutput("freeze mu_addr", bus.mu_addr, 32'h500);
      checkOutput("freeze mu_len", 32'(bus.mu_len), 32'h1);
      checkOutput("freeze mu_valid", 32'(bus.mu_valid), 32'h1);
      checkOutput("freeze ls_ready", 32'(bus.ls_ready), 32'h0);
      toCycle();
      toCycle();
      rdy_in = 1'b1;
      probe();
      checkOutput("freeze c5 ls_ready", 32'(bus.ls_ready), 32'h0);
      toCycle();
      probe();
      checkOutput("freeze c6 ls_ready", 32'(bus.ls_ready), 32'h1);
      checkOutput("freeze c6 ls_data_out", bus.ls_data_out, 32'hFFFF8001);
      toCycle();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0);

      // Flush coincident with completion suppresses the ready pulse
      toCycle();
      readData = 32'h12;
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h700, 3'b000, 32'h0);
      toCycle();
      toCycle();
      rob_clear = 1'b1;
      probe();
      checkOutput("clr+ready ls_ready", 32'(bus.ls_ready), 32'h0);
      checkOutput("clr+ready ls_data_out", bus.ls_data_out, 32'h0);
      toCycle();
      rob_clear = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
      probe();
      checkOutput("clr+ready idle mu_valid", 32'(bus.mu_valid), 32'h0);

      // UART store with full buffer and a pending fetch, last owner IF
      doReset();
      toCycle();
      io_buffer_full = 1'b1;
      readData       = 32'h77;
      applyStimulus(1'b1, 32'h600, 1'b1, 1'b1, 32'h30000, 3'b010, 32'h55);
      toCycle();
      probe();
`ifdef MEM_ARB_IO_STALL_EN
      checkOutput("io fetch first mu_addr", bus.mu_addr, 32'h600);
      checkOutput("io fetch first mu_wr", 32'(bus.mu_wr), 32'h0);
      repeat (4) toCycle();
      probe();
      checkOutput("io fetch if_ready", 32'(bus.if_ready), 32'h1);
      toCycle();
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h30000, 3'b010, 32'h55);
      probe();
      checkOutput("io stalled c6 mu_valid", 32'(bus.mu_valid), 32'h0);
      toCycle();
      probe();
      checkOutput("io stalled c7 mu_valid", 32'(bus.mu_valid), 32'h0);
      toCycle();
      io_buffer_full = 1'b0;
      probe();
      checkOutput("io release c8 mu_valid", 32'(bus.mu_valid), 32'h0);
      toCycle();
      probe();
      checkOutput("io store mu_valid", 32'(bus.mu_valid), 32'h1);
      checkOutput("io store mu_addr", bus.mu_addr, 32'h30000);
      checkOutput("io store mu_data", bus.mu_data, 32'h55);
`else
      checkOutput("io store first mu_addr", bus.mu_addr, 32'h30000);
      checkOutput("io store first mu_wr", 32'(bus.mu_wr), 32'h1);
      checkOutput("io store first mu_data", bus.mu_data, 32'h55);
      repeat (4) toCycle();
      probe();
      checkOutput("io store ls_ready", 32'(bus.ls_ready), 32'h1);
      checkOutput("io store no if_ready", 32'(bus.if_ready), 32'h0);
      toCycle();
      applyStimulus(1'b1, 32'h600, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
      probe();
      checkOutput("io gap mu_valid", 32'(bus.mu_valid), 32'h0);
      toCycle();
      probe();
      checkOutput("io fetch mu_valid", 32'(bus.mu_valid), 32'h1);
      checkOutput("io fetch mu_addr", bus.mu_addr, 32'h600);
`endif
      toCycle();
      io_buffer_full = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
      repeat (6) toCycle();

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
